// File: rtl/bist_responder.sv
// BIST datapath responder: LFSR pattern source, MISR response compactor and pass/fail verdict.
// Optional BIST_EXPECT_COUNT_EN: a pass also requires exactly EXPECT_COUNT compacted patterns.
module bist_responder #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] SEED         = 8'h01,
    parameter logic [WIDTH-1:0] POLY         = 8'hB8,
    parameter logic [WIDTH-1:0] GOLDEN       = 8'h00,
    parameter int               CNT_W        = 8,
    parameter int               EXPECT_COUNT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             running,
    input  logic             toggle,
    input  logic             finish,
    input  logic             bist_end,
    input  logic [WIDTH-1:0] cut_resp,
    output logic [WIDTH-1:0] pattern,
    output logic             test_mode,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] pattern_count,
    output logic             result_valid,
    output logic             pass,
    output logic             fail,
    output logic             aborted
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARMED, S_RUN, S_HOLD, S_CHECK, S_DONE
    } state_t;

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_misr;
    logic [CNT_W-1:0] r_count;
    logic             r_phase;
    logic             r_overflow;
    logic             r_result_valid;
    logic             r_pass;
    logic             r_fail;
    logic             r_aborted;

    logic             w_active;
    logic             w_abort;
    logic             w_compact;
    logic             w_count_ok;
    logic             w_pass;
    logic [WIDTH-1:0] w_lfsr_step;
    logic [WIDTH-1:0] w_misr_step;

    assign w_active  = (r_state == S_ARMED) || (r_state == S_RUN) || (r_state == S_HOLD);
    assign w_abort   = !init && bist_end && (w_active || (r_state == S_LOAD));
    assign w_compact = !init && !bist_end && (r_state == S_RUN) && running;

    assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? POLY : '0);
    assign w_misr_step = (r_misr >> 1) ^ (r_misr[0] ? POLY : '0) ^ cut_resp;

`ifdef BIST_EXPECT_COUNT_EN
    assign w_count_ok = (r_count == CNT_W'(EXPECT_COUNT));
`else
    logic w_unused_expect;
    assign w_unused_expect = (EXPECT_COUNT == 0);
    assign w_count_ok      = 1'b1;
`endif

    assign w_pass = (r_misr == GOLDEN) && !r_overflow && w_count_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (init) begin
            w_next = S_LOAD;
        end else if (w_abort) begin
            w_next = S_DONE;
        end else begin
            case (r_state)
                S_LOAD:  w_next = S_ARMED;
                S_ARMED: if (running) w_next = S_RUN;
                S_RUN:   if (finish) w_next = S_CHECK;
                         else if (!running) w_next = S_HOLD;
                S_HOLD:  if (finish) w_next = S_CHECK;
                         else if (running) w_next = S_RUN;
                S_CHECK: w_next = S_DONE;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr         <= '0;
            r_misr         <= '0;
            r_count        <= '0;
            r_phase        <= 1'b0;
            r_overflow     <= 1'b0;
            r_result_valid <= 1'b0;
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_aborted      <= 1'b0;
        end else if (init) begin
            r_result_valid <= 1'b0;
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_aborted      <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_lfsr         <= SEED_EFF;
                r_misr         <= '0;
                r_count        <= '0;
                r_phase        <= 1'b0;
                r_overflow     <= 1'b0;
                r_result_valid <= 1'b0;
                r_pass         <= 1'b0;
                r_fail         <= 1'b0;
                r_aborted      <= 1'b0;
            end
            if (w_compact) begin
                r_lfsr <= w_lfsr_step;
                r_misr <= w_misr_step;
                if (&r_count) r_overflow <= 1'b1;
                else          r_count    <= r_count + 1'b1;
            end
            if (toggle && w_active) r_phase <= ~r_phase;
            // Abort assignments come last so they win over the LOAD clear.
            if (w_abort) begin
                r_result_valid <= 1'b1;
                r_pass         <= 1'b0;
                r_fail         <= 1'b1;
                r_aborted      <= 1'b1;
            end
            if (r_state == S_CHECK) begin
                r_result_valid <= 1'b1;
                r_pass         <= w_pass;
                r_fail         <= !w_pass;
                r_aborted      <= 1'b0;
            end
        end
    end

    assign test_mode     = w_active;
    assign pattern       = w_active ? (r_lfsr ^ {WIDTH{r_phase}}) : '0;
    assign signature     = r_misr;
    assign pattern_count = r_count;
    assign result_valid  = r_result_valid;
    assign pass          = r_pass;
    assign fail          = r_fail;
    assign aborted       = r_aborted;

endmodule
